// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle over XLEN cycles, with single-cycle divide special cases.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   addend_q, addend_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   stage_q, stage_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sa, sb, is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   a_abs, b_abs, special_res, fin_res, quo, rem;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   trial;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, mul_signed;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only rs1.
    always_comb begin
        sa          = rs1[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                     funct3 == 3'b100 || funct3 == 3'b110);
        sb          = rs2[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 ||
                                     funct3 == 3'b110);
        a_abs       = sa ? -rs1 : rs1;
        b_abs       = sb ? -rs2 : rs2;
        is_div      = funct3[2];
        div_zero    = (rs2 == '0);
        div_ovf     = !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        special_res = div_zero ? (funct3[1] ? rs1 : '1)
                               : (funct3[1] ? '0  : MIN_NEG);
    end

    // prod_q is {product_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend_q};
        mul_next  = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        trial     = {1'b0, prod_q[2*XLEN-1:XLEN-1]} - {2'b0, addend_q};
        div_next  = trial[XLEN+1] ? {prod_q[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        iter_next = op_q[2] ? div_next : mul_next;

        mul_signed = neg_q ? -iter_next : iter_next;
        quo        = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem        = neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         fin_res = mul_signed[XLEN-1:0];
            3'b100, 3'b101: fin_res = quo;
            3'b110, 3'b111: fin_res = rem;
            default:        fin_res = mul_signed[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addend_d = addend_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        stage_d  = stage_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d     = funct3;
                    cnt_d    = '0;
                    addend_d = is_div ? b_abs : a_abs;
                    prod_d   = {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                    // Remainder takes the dividend's sign; everything else sA^sB.
                    neg_d    = (is_div && funct3[1]) ? sa : (sa ^ sb);
                    if (is_div && (div_zero || div_ovf)) begin
                        stage_d = special_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = iter_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        stage_d = fin_res;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) result_d = stage_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            addend_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            stage_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addend_q <= addend_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            stage_q  <= stage_d;
            result_q <= result_d;
        end
    end

    // A flush in DONE kills the pulse and leaves the held result untouched.
    assign ready        = (state_q == IDLE);
    assign result_valid = (state_q == DONE) && !flush;
    assign result       = result_valid ? stage_q : result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        ready, result_valid;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .flush(flush),
        .ready(ready), .result_valid(result_valid), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge showing result_valid.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_bad);
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 1; busy_bad = 0;
        while (!result_valid && lat < 60) begin
            if (ready !== 1'b0) busy_bad++;
            @(negedge clock);
            lat++;
        end
        if (ready !== 1'b0) busy_bad++;
        res = result;
    endtask

    task automatic no_valid_for(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (result_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] res, prev;
        int lat, bad, cnt;

        vecs[0]  = '{"mul_7x6",       3'b000, 32'd7,        32'd6,        32'd42,       33};
        vecs[1]  = '{"mul_m3x5",      3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33};
        vecs[2]  = '{"mulh_m1xm1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{"mulh_min2",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[4]  = '{"mulhu_max2",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[5]  = '{"mulhu_carry",   3'b011, 32'h80000000, 32'd2,        32'h00000001, 33};
        vecs[6]  = '{"mulhsu_m1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        vecs[7]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[8]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[9]  = '{"div_7_m2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[10] = '{"rem_7_m2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33};
        vecs[11] = '{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33};
        vecs[12] = '{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[13] = '{"divu_max_1",    3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
        vecs[14] = '{"div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[15] = '{"rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[16] = '{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[17] = '{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bad);
            chk({vecs[i].name, "_result"}, res, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 32'(bad), 32'd0);
            @(negedge clock);
            chk({vecs[i].name, "_pulse"}, 32'(result_valid), 32'd0);
            chk({vecs[i].name, "_ready_after"}, 32'(ready), 32'd1);
            chk({vecs[i].name, "_hold"}, result, vecs[i].exp);
        end

        // Flush in IDLE beats a coincident start (special case would pulse next cycle).
        prev = result;
        start = 1'b1; flush = 1'b1; funct3 = 3'b100; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_valid", 32'(result_valid), 32'd0);
        chk("idle_flush_ready", 32'(ready), 32'd1);

        // Flush during DONE suppresses the pulse and does not update result.
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; flush = 1'b1;
        #1;
        chk("done_flush_valid", 32'(result_valid), 32'd0);
        chk("done_flush_result", result, prev);
        @(negedge clock);
        flush = 1'b0;
        chk("done_flush_ready", 32'(ready), 32'd1);
        chk("done_flush_hold", result, prev);

        // Flush DIVU in the middle of iteration.
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("calc_flush_ready", 32'(ready), 32'd1);
        chk("calc_flush_valid", 32'(result_valid), 32'd0);
        no_valid_for("calc_flush_no_pulse", 40);
        chk("calc_flush_hold", result, prev);
        run_op(3'b000, 32'd3, 32'd3, res, lat, bad);
        chk("post_flush_mul", res, 32'd9);
        chk("post_flush_latency", 32'(lat), 32'd33);
        @(negedge clock);

        // Reset mid-operation aborts with no result pulse.
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midop_reset_ready", 32'(ready), 32'd1);
        chk("midop_reset_valid", 32'(result_valid), 32'd0);
        chk("midop_reset_result", result, 32'd0);
        reset = 1'b0;
        no_valid_for("midop_reset_no_pulse", 40);

        // Start held across DONE: second op is accepted the cycle after the pulse.
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6;
        @(posedge clock);
        @(negedge clock);
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        cnt = 1;
        while (!result_valid && cnt < 60) begin
            @(negedge clock);
            cnt++;
        end
        chk("hold_first_latency", 32'(cnt), 32'd33);
        chk("hold_first_result", result, 32'd42);
        chk("hold_done_ready", 32'(ready), 32'd0);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == 1) chk("hold_idle_ready", 32'(ready), 32'd1);
            if (cnt == 2) start = 1'b0;
        end while (!result_valid && cnt < 80);
        chk("hold_second_latency", 32'(cnt), 32'd34);
        chk("hold_second_result", result, 32'd14);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
